// File: rtl/risc_mc_pkg.sv
// Shared opcodes, instruction classes and FSM states for the multi-cycle RISC core.
package risc_mc_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_MUL   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_INV   = 5'd5;
  localparam logic [4:0] OP_LSL   = 5'd6;
  localparam logic [4:0] OP_LSR   = 5'd7;
  localparam logic [4:0] OP_DEC   = 5'd8;
  localparam logic [4:0] OP_INC   = 5'd9;
  localparam logic [4:0] OP_MOV   = 5'd10;
  localparam logic [4:0] OP_SLT   = 5'd11;
  localparam logic [4:0] OP_ADDI  = 5'd12;
  localparam logic [4:0] OP_SUBI  = 5'd13;
  localparam logic [4:0] OP_SLTI  = 5'd14;
  localparam logic [4:0] OP_MOVI  = 5'd15;
  localparam logic [4:0] OP_BNEQ  = 5'd16;
  localparam logic [4:0] OP_BEQ   = 5'd17;
  localparam logic [4:0] OP_BEQZ  = 5'd18;
  localparam logic [4:0] OP_BNEQZ = 5'd19;
  localparam logic [4:0] OP_LD    = 5'd20;
  localparam logic [4:0] OP_ST    = 5'd21;
  localparam logic [4:0] OP_HLT   = 5'd22;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, ILLEGAL
  } ex_type_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
  } state_t;

  function automatic ex_type_t decode_op(input logic [4:0] op);
    ex_type_t t;
    if (op <= OP_SLT)        t = RR_ALU;
    else if (op <= OP_MOVI)  t = RM_ALU;
    else if (op <= OP_BNEQZ) t = BRANCH;
    else if (op == OP_LD)    t = LOAD;
    else if (op == OP_ST)    t = STORE;
    else if (op == OP_HLT)   t = HALT;
    else                     t = ILLEGAL;
    return t;
  endfunction

endpackage

// File: rtl/risc_mc_core_param_alu.sv
// Combinational ALU: register/immediate arithmetic, load/store address and branch condition.
module risc_mc_alu
  import risc_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              br_cond
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  always_comb begin
    result  = '0;
    br_cond = 1'b0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_MUL:   result = a * b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_INV:   result = ~a;
      OP_LSL:   result = a << b;
      OP_LSR:   result = a >> b;
      OP_DEC:   result = a - ONE;
      OP_INC:   result = a + ONE;
      OP_MOV:   result = a;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_ADDI:  result = a + imm;
      OP_SUBI:  result = a - imm;
      OP_SLTI:  result = {{(DATA_W-1){1'b0}}, (a < imm)};
      OP_MOVI:  result = imm;
      OP_BNEQ:  br_cond = (a != b);
      OP_BEQ:   br_cond = (a == b);
      OP_BEQZ:  br_cond = (a == '0);
      OP_BNEQZ: br_cond = (a != '0);
      OP_LD,
      OP_ST:    result = b + imm;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/risc_mc_core_param.sv
// Multi-cycle RISC core, one instruction in flight, with an internal unified word memory
// loaded by the host while idle or halted.
//
// state  | meaning
// IDLE   | after reset, waiting for start; host may load memory
// FETCH  | IR <= mem[PC], NPC <= PC, PC++
// DECODE | read operands, sign-extend immediate
// EXEC   | ALU result / address / branch condition
// MEM    | load or store data access
// WB     | register write-back, branch redirect, retire or halt
// HALTED | stopped after HLT or illegal opcode; host may load memory or restart
module risc_mc_core_param
  import risc_mc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int RESULT_REG = 2,
  parameter int CNT_W      = 32,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     start_pc,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [AW-1:0]    PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       RES_IDX = 3'(RESULT_REG);

  state_t            state, state_nxt;
  logic [AW-1:0]     pc, npc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, imm, lmd;
  logic              br_taken;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  ex_type_t          ex_type;
  logic [DATA_W-1:0] alu_res;
  logic              br_cond;
  logic [AW-1:0]     mem_addr;
  logic              host_wr, mem_wr;

  assign ex_type  = decode_op(ir[15:11]);
  assign mem_addr = alu_out[AW-1:0];
  assign host_wr  = ld_en && (state == IDLE || state == HALTED);
  assign mem_wr   = (state == MEM) && (ex_type == STORE);
  assign dbg_data = regs[dbg_sel];

  risc_mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (ir[15:11]),
    .a       (a),
    .b       (b),
    .imm     (imm),
    .result  (alu_res),
    .br_cond (br_cond)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALTED: if (start) state_nxt = FETCH;
      FETCH:        state_nxt = DECODE;
      DECODE:       state_nxt = EXEC;
      EXEC:         state_nxt = MEM;
      MEM:          state_nxt = WB;
      WB:           state_nxt = (ex_type == HALT || ex_type == ILLEGAL) ? HALTED : FETCH;
      default:      state_nxt = IDLE;
    endcase
  end

  // Memory has no reset; host and core writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (host_wr)     mem[ld_addr]  <= ld_data;
    else if (mem_wr) mem[mem_addr] <= a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      npc      <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      imm      <= '0;
      lmd      <= '0;
      alu_out  <= '0;
      result   <= '0;
      retired  <= '0;
      br_taken <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc      <= start_pc;
            retired <= '0;
            err     <= 1'b0;
            halted  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          ir  <= mem[pc][15:0];
          npc <= pc;
          pc  <= pc + PC_ONE;
        end
        DECODE: begin
          a   <= regs[ir[10:8]];
          b   <= regs[ir[7:5]];
          imm <= {{(DATA_W-5){ir[4]}}, ir[4:0]};
        end
        EXEC: begin
          if (ex_type inside {RR_ALU, RM_ALU, LOAD, STORE}) alu_out <= alu_res;
          br_taken <= (ex_type == BRANCH) && br_cond;
        end
        MEM: begin
          if (ex_type == LOAD) lmd <= mem[mem_addr];
        end
        WB: begin
          case (ex_type)
            RR_ALU: regs[ir[4:2]]  <= alu_out;
            RM_ALU: regs[ir[7:5]]  <= alu_out;
            LOAD:   regs[ir[10:8]] <= lmd;
            BRANCH: if (br_taken) pc <= npc + imm[AW-1:0];
            HALT, ILLEGAL: begin
              result <= regs[RES_IDX];
              halted <= 1'b1;
              busy   <= 1'b0;
              err    <= (ex_type == ILLEGAL);
            end
            default: ;
          endcase
          if (ex_type != ILLEGAL) retired <= retired + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_mc_core_param.sv
// Directed bench: default core (16-bit, 1024 words) and a 32-bit / 16-word core with RESULT_REG=3.
module tb_risc_mc_core_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        ld_en0 = 1'b0, ld_en1 = 1'b0;
  logic [9:0]  start_pc = '0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [2:0]  dbg_sel = '0;

  logic [15:0] dbg_data0, alu_out0, result0;
  logic        busy0, halted0, err0;
  logic [31:0] retired0;
  logic [31:0] dbg_data1, alu_out1, result1;
  logic        busy1, halted1, err1;
  logic [31:0] retired1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  risc_mc_core_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_pc(start_pc),
    .ld_en(ld_en0), .ld_addr(ld_addr), .ld_data(ld_data[15:0]),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data0), .busy(busy0), .halted(halted0),
    .err(err0), .alu_out(alu_out0), .result(result0), .retired(retired0)
  );

  risc_mc_core_param #(.DATA_W(32), .MEM_DEPTH(16), .RESULT_REG(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_pc(start_pc[3:0]),
    .ld_en(ld_en1), .ld_addr(ld_addr[3:0]), .ld_data(ld_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data1), .busy(busy1), .halted(halted1),
    .err(err1), .alu_out(alu_out1), .result(result1), .retired(retired1)
  );

  function automatic logic [31:0] enc(input int op, input int r1, input int r2, input int low);
    logic [31:0] w;
    w = {16'h0, op[4:0], r1[2:0], r2[2:0], low[4:0]};
    return w;
  endfunction

  task automatic load_word(input int sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    ld_addr = 10'(addr);
    ld_data = data;
    if (sel == 0) ld_en0 = 1'b1; else ld_en1 = 1'b1;
    @(negedge clk);
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
  endtask

  // Returns negedges from the start edge until halted (budget if it never halts).
  task automatic run_prog(input int sel, input int pc, input int budget, output int cyc);
    @(negedge clk);
    start_pc = 10'(pc);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 0;
    while (((sel == 0) ? !halted0 : !halted1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_max_search();
    load_word(0, 0, enc(15, 0, 2, 0));
    load_word(0, 1, enc(15, 0, 4, 8));
    load_word(0, 2, enc(20, 3, 4, 15));
    load_word(0, 3, enc(11, 2, 3, 5 << 2));
    load_word(0, 4, enc(18, 5, 0, 2));
    load_word(0, 5, enc(10, 3, 0, 2 << 2));
    load_word(0, 6, enc(8, 4, 0, 4 << 2));
    load_word(0, 7, enc(19, 4, 0, 5'h1B));
    load_word(0, 8, enc(22, 0, 0, 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    dbg_sel = 3'd2;
    #1;
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0 got %b want 0", busy0); end
    n_vec++; if (halted0 !== 1'b0) begin n_err++; $display("FAIL reset_halted0 got %b want 0", halted0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL reset_err0 got %b want 0", err0); end
    n_vec++; if (alu_out0 !== 16'h0) begin n_err++; $display("FAIL reset_alu_out0 got %h want 0", alu_out0); end
    n_vec++; if (result0 !== 16'h0) begin n_err++; $display("FAIL reset_result0 got %h want 0", result0); end
    n_vec++; if (retired0 !== 32'h0) begin n_err++; $display("FAIL reset_retired0 got %0d want 0", retired0); end
    n_vec++; if (dbg_data0 !== 16'h0) begin n_err++; $display("FAIL reset_r2 got %h want 0", dbg_data0); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_search();
    int cyc;
    int data [8] = '{0, 121, 14, 9, 123, 231, 78, 94};
    load_max_search();
    for (int i = 0; i < 8; i++) load_word(0, 16 + i, 32'(data[i]));
    run_prog(0, 0, 400, cyc);
    n_vec++; if (cyc !== 225) begin n_err++; $display("FAIL max_cycles got %0d want 225", cyc); end
    n_vec++; if (result0 !== 16'd231) begin n_err++; $display("FAIL max_result got %0d want 231", result0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL max_err got %b want 0", err0); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL max_busy got %b want 0", busy0); end
    n_vec++; if (retired0 !== 32'd45) begin n_err++; $display("FAIL max_retired got %0d want 45", retired0); end
    dbg_sel = 3'd4;
    #1;
    n_vec++; if (dbg_data0 !== 16'd0) begin n_err++; $display("FAIL max_r4 got %0d want 0", dbg_data0); end
  endtask

  task automatic test_ldst();
    int cyc;
    load_word(1, 0, enc(15, 0, 1, 5));
    load_word(1, 1, enc(21, 1, 0, 10));
    load_word(1, 2, enc(20, 3, 0, 10));
    load_word(1, 3, enc(22, 0, 0, 0));
    run_prog(1, 0, 100, cyc);
    n_vec++; if (cyc !== 20) begin n_err++; $display("FAIL ldst_cycles got %0d want 20", cyc); end
    n_vec++; if (result1 !== 32'd5) begin n_err++; $display("FAIL ldst_result got %0d want 5", result1); end
    n_vec++; if (retired1 !== 32'd4) begin n_err++; $display("FAIL ldst_retired got %0d want 4", retired1); end
    n_vec++; if (err1 !== 1'b0) begin n_err++; $display("FAIL ldst_err got %b want 0", err1); end
  endtask

  task automatic test_wrap();
    int cyc;
    load_word(1, 13, enc(15, 0, 1, 5'h1F));
    load_word(1, 14, enc(15, 0, 2, 1));
    load_word(1, 15, enc(0, 1, 2, 3 << 2));
    load_word(1, 0, enc(9, 4, 0, 4 << 2));
    load_word(1, 1, enc(17, 4, 2, 5'h1E));
    load_word(1, 2, enc(22, 0, 0, 0));
    run_prog(1, 13, 100, cyc);
    n_vec++; if (cyc !== 45) begin n_err++; $display("FAIL wrap_cycles got %0d want 45", cyc); end
    n_vec++; if (result1 !== 32'd0) begin n_err++; $display("FAIL wrap_add_result got %h want 0", result1); end
    n_vec++; if (retired1 !== 32'd9) begin n_err++; $display("FAIL wrap_retired got %0d want 9", retired1); end
    dbg_sel = 3'd4;
    #1;
    n_vec++; if (dbg_data1 !== 32'd2) begin n_err++; $display("FAIL wrap_r4 got %0d want 2", dbg_data1); end
    dbg_sel = 3'd1;
    #1;
    n_vec++; if (dbg_data1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_r1 got %h want ffffffff", dbg_data1); end
  endtask

  task automatic test_illegal();
    int cyc;
    load_word(0, 0, enc(31, 0, 0, 0));
    run_prog(0, 0, 50, cyc);
    n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL ill_cycles got %0d want 5", cyc); end
    n_vec++; if (halted0 !== 1'b1) begin n_err++; $display("FAIL ill_halted got %b want 1", halted0); end
    n_vec++; if (err0 !== 1'b1) begin n_err++; $display("FAIL ill_err got %b want 1", err0); end
    n_vec++; if (retired0 !== 32'd0) begin n_err++; $display("FAIL ill_retired got %0d want 0", retired0); end
    n_vec++; if (result0 !== 16'd231) begin n_err++; $display("FAIL ill_result got %0d want 231", result0); end
    dbg_sel = 3'd2;
    #1;
    n_vec++; if (dbg_data0 !== 16'd231) begin n_err++; $display("FAIL ill_r2 got %0d want 231", dbg_data0); end
  endtask

  task automatic test_host_write_busy();
    int cyc;
    load_word(0, 0, enc(15, 0, 2, 7));
    load_word(0, 1, enc(22, 0, 0, 0));
    @(negedge clk);
    start_pc = 10'd0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL hw_busy got %b want 1", busy0); end
    ld_addr = 10'd0;
    ld_data = 32'h0000_FFFF;
    ld_en0 = 1'b1;
    cyc = 0;
    while (!halted0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ld_en0 = 1'b0;
    n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL hw_cycles got %0d want 10", cyc); end
    n_vec++; if (result0 !== 16'd7) begin n_err++; $display("FAIL hw_result got %0d want 7", result0); end
    run_prog(0, 0, 50, cyc);
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL hw_rerun_err got %b want 0", err0); end
    n_vec++; if (retired0 !== 32'd2) begin n_err++; $display("FAIL hw_rerun_retired got %0d want 2", retired0); end
    load_word(0, 0, 32'h0000_FFFF);
    run_prog(0, 0, 50, cyc);
    n_vec++; if (err0 !== 1'b1) begin n_err++; $display("FAIL hw_after_halt_err got %b want 1", err0); end
    n_vec++; if (retired0 !== 32'd0) begin n_err++; $display("FAIL hw_after_halt_retired got %0d want 0", retired0); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_word(0, 0, enc(15, 0, 2, 0));
    load_word(0, 1, enc(15, 0, 4, 8));
    @(negedge clk);
    start_pc = 10'd0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    dbg_sel = 3'd4;
    #1;
    n_vec++; if (retired0 !== 32'd4) begin n_err++; $display("FAIL mid_retired_pre got %0d want 4", retired0); end
    n_vec++; if (dbg_data0 !== 16'd8) begin n_err++; $display("FAIL mid_r4_pre got %0d want 8", dbg_data0); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy0); end
    n_vec++; if (retired0 !== 32'd0) begin n_err++; $display("FAIL mid_retired got %0d want 0", retired0); end
    n_vec++; if (alu_out0 !== 16'd0) begin n_err++; $display("FAIL mid_alu_out got %h want 0", alu_out0); end
    n_vec++; if (result0 !== 16'd0) begin n_err++; $display("FAIL mid_result got %h want 0", result0); end
    n_vec++; if (dbg_data0 !== 16'd0) begin n_err++; $display("FAIL mid_r4 got %0d want 0", dbg_data0); end
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(0, 0, 400, cyc);
    n_vec++; if (result0 !== 16'd231) begin n_err++; $display("FAIL mid_restart_result got %0d want 231", result0); end
    n_vec++; if (cyc !== 225) begin n_err++; $display("FAIL mid_restart_cycles got %0d want 225", cyc); end
  endtask

  initial begin
    test_reset();
    test_max_search();
    test_ldst();
    test_wrap();
    test_illegal();
    test_host_write_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
